// File: rtl/sketch_counter_sched_pkg.sv
// Shared widths, update-function encodings and scheduler state encodings
// for the sketch counter read-modify-write scheduler.
package sketch_counter_sched_pkg;

    localparam int SRAM_ADDR_WIDTH = 19;
    localparam int SRAM_DATA_WIDTH = 36;
    localparam int CNT_WIDTH       = 32;
    localparam int FIFO_DEPTH_BITS = 2;
    localparam int UPD_REQ_WIDTH   = SRAM_ADDR_WIDTH + 2 + CNT_WIDTH;

    localparam logic [1:0] UPD_FUNC_ADD = 2'd0;
    localparam logic [1:0] UPD_FUNC_MAX = 2'd1;
    localparam logic [1:0] UPD_FUNC_SET = 2'd2;
    localparam logic [1:0] UPD_FUNC_SUB = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_ACK     = 3'd4
    } sched_state_t;

    typedef enum logic {
        GRANT_UPD = 1'b0,
        GRANT_SW  = 1'b1
    } grant_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout always shows the head entry
// whenever empty is low.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(1);
    localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = (MAX_DEPTH_BITS + 1)'(1);
    localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL = (MAX_DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      push;
    logic                      pop;

    assign full  = (depth == CNT_FULL);
    assign empty = (depth == '0);
    assign dout  = mem[rd_ptr];
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   depth <= depth + CNT_ONE;
                2'b01:   depth <= depth - CNT_ONE;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/sketch_counter_sched_alu.sv
// Combinational counter update: saturating add/sub, max and set on
// unsigned counter words.
module counter_alu
    import sketch_counter_sched_pkg::*;
(
    input  logic [CNT_WIDTH-1:0] old_cnt,
    input  logic [CNT_WIDTH-1:0] value,
    input  logic [1:0]           func,
    output logic [CNT_WIDTH-1:0] new_cnt
);

    logic [CNT_WIDTH:0] sum;

    assign sum = {1'b0, old_cnt} + {1'b0, value};

    always_comb begin
        new_cnt = old_cnt;
        unique case (func)
            UPD_FUNC_ADD: new_cnt = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
            UPD_FUNC_MAX: new_cnt = (value > old_cnt) ? value : old_cnt;
            UPD_FUNC_SET: new_cnt = value;
            UPD_FUNC_SUB: new_cnt = (value > old_cnt) ? '0 : (old_cnt - value);
            default:      new_cnt = old_cnt;
        endcase
    end

endmodule

// File: rtl/sketch_counter_sched.sv
// Read-modify-write scheduler for the sketch counter SRAM: queues counter
// updates, arbitrates them against host accesses, one SRAM op in flight.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | pick next op: queued update or host access (round-robin)
// ST_RD_REQ  | SRAM read request outstanding, waiting for sram_ack
// ST_RD_WAIT | read accepted, waiting for sram_rd_vld
// ST_WR_REQ  | SRAM write request outstanding, waiting for sram_ack
// ST_ACK     | host op complete; sw_ack pulses on the following cycle
module sketch_counter_sched
    import sketch_counter_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] upd_addr,
    input  logic [1:0]                 upd_func,
    input  logic [CNT_WIDTH-1:0]       upd_value,
    input  logic                       sw_req,
    input  logic                       sw_wr,
    input  logic [SRAM_ADDR_WIDTH-1:0] sw_addr,
    input  logic [CNT_WIDTH-1:0]       sw_wr_data,
    output logic                       sw_ack,
    output logic [CNT_WIDTH-1:0]       sw_rd_data,
    output logic                       sram_req,
    output logic                       sram_rd_wr_L,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic                       sram_ack,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    input  logic                       sram_rd_vld,
    output logic [CNT_WIDTH-1:0]       upd_done,
    output logic                       busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    sched_state_t state_q, state_d;
    grant_t       last_grant_q;

    logic [UPD_REQ_WIDTH-1:0]   fifo_din;
    logic [UPD_REQ_WIDTH-1:0]   fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic [SRAM_ADDR_WIDTH-1:0] head_addr;
    logic [1:0]                 head_func;
    logic [CNT_WIDTH-1:0]       head_value;

    logic                       op_is_sw_q;
    logic [SRAM_ADDR_WIDTH-1:0] op_addr_q;
    logic [1:0]                 op_func_q;
    logic [CNT_WIDTH-1:0]       op_value_q;

    logic                       upd_cand;
    logic                       sw_cand;
    logic                       grant_upd;
    logic                       grant_sw;
    logic                       issue_rd;
    logic                       issue_wr;
    logic                       sw_rd_load;
    logic                       done_inc;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_d;
    logic [CNT_WIDTH-1:0]       wr_cnt_d;
    logic [CNT_WIDTH-1:0]       alu_new;
    logic                       rd_hi_unused;

    assign fifo_din                           = {upd_addr, upd_func, upd_value};
    assign {head_addr, head_func, head_value} = fifo_dout;
    assign upd_ready                          = !fifo_full;
    assign busy                               = (state_q != ST_IDLE) || !fifo_empty;
    assign rd_hi_unused                       = ^sram_rd_data[SRAM_DATA_WIDTH-1:CNT_WIDTH];

    fallthrough_small_fifo #(
        .WIDTH          (UPD_REQ_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_upd_fifo (
        .din   (fifo_din),
        .wr_en (upd_valid && upd_ready),
        .rd_en (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .reset (reset),
        .clk   (clk)
    );

    counter_alu u_alu (
        .old_cnt (sram_rd_data[CNT_WIDTH-1:0]),
        .value   (op_value_q),
        .func    (op_func_q),
        .new_cnt (alu_new)
    );

    // A host request is ignored while its own ack is still showing, so a
    // held sw_req cannot be granted twice.
    assign upd_cand = !fifo_empty;
    assign sw_cand  = sw_req && !sw_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        grant_upd   = 1'b0;
        grant_sw    = 1'b0;
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        sw_rd_load  = 1'b0;
        done_inc    = 1'b0;
        sram_addr_d = op_addr_q;
        wr_cnt_d    = op_value_q;
        unique case (state_q)
            ST_IDLE: begin
                if (upd_cand && (!sw_cand || last_grant_q == GRANT_SW)) begin
                    grant_upd   = 1'b1;
                    fifo_pop    = 1'b1;
                    issue_rd    = 1'b1;
                    sram_addr_d = head_addr;
                    state_d     = ST_RD_REQ;
                end else if (sw_cand) begin
                    grant_sw    = 1'b1;
                    sram_addr_d = sw_addr;
                    if (sw_wr) begin
                        issue_wr = 1'b1;
                        wr_cnt_d = sw_wr_data;
                        state_d  = ST_WR_REQ;
                    end else begin
                        issue_rd = 1'b1;
                        state_d  = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (sram_req && sram_ack) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (sram_rd_vld) begin
                    if (op_is_sw_q) begin
                        sw_rd_load = 1'b1;
                        state_d    = ST_ACK;
                    end else begin
                        issue_wr = 1'b1;
                        wr_cnt_d = alu_new;
                        state_d  = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (sram_req && sram_ack) begin
                    if (op_is_sw_q) begin
                        state_d = ST_ACK;
                    end else begin
                        done_inc = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_SW;
            op_is_sw_q   <= 1'b0;
            op_addr_q    <= '0;
            op_func_q    <= '0;
            op_value_q   <= '0;
            sram_req     <= 1'b0;
            sram_rd_wr_L <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
            sw_ack       <= 1'b0;
            sw_rd_data   <= '0;
            upd_done     <= '0;
        end else begin
            sw_ack <= (state_q == ST_ACK);
            if (grant_upd) begin
                last_grant_q <= GRANT_UPD;
                op_is_sw_q   <= 1'b0;
                op_addr_q    <= head_addr;
                op_func_q    <= head_func;
                op_value_q   <= head_value;
            end
            if (grant_sw) begin
                last_grant_q <= GRANT_SW;
                op_is_sw_q   <= 1'b1;
                op_addr_q    <= sw_addr;
            end
            if (issue_rd || issue_wr) begin
                sram_req     <= 1'b1;
                sram_rd_wr_L <= issue_rd;
                sram_addr    <= sram_addr_d;
                sram_wr_data <= {{(SRAM_DATA_WIDTH - CNT_WIDTH){1'b0}}, wr_cnt_d};
            end else if (sram_req && sram_ack) begin
                sram_req <= 1'b0;
            end
            if (sw_rd_load) begin
                sw_rd_data <= sram_rd_data[CNT_WIDTH-1:0];
            end
            if (done_inc) begin
                upd_done <= upd_done + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sketch_counter_sched.sv
// Scoreboard bench for sketch_counter_sched: directed updates and host
// accesses against a behavioural single-port SRAM.
module tb_sketch_counter_sched;
    import sketch_counter_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [18:0] upd_addr = '0;
    logic [1:0]  upd_func = '0;
    logic [31:0] upd_value = '0;
    logic        sw_req = 1'b0;
    logic        sw_wr = 1'b0;
    logic [18:0] sw_addr = '0;
    logic [31:0] sw_wr_data = '0;
    logic        sw_ack;
    logic [31:0] sw_rd_data;
    logic        sram_req;
    logic        sram_rd_wr_L;
    logic [18:0] sram_addr;
    logic [35:0] sram_wr_data;
    logic        sram_ack;
    logic [35:0] sram_rd_data;
    logic        sram_rd_vld;
    logic [31:0] upd_done;
    logic        busy;

    always #5 clk = ~clk;

    sketch_counter_sched dut (
        .clk          (clk),
        .reset        (reset),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_addr     (upd_addr),
        .upd_func     (upd_func),
        .upd_value    (upd_value),
        .sw_req       (sw_req),
        .sw_wr        (sw_wr),
        .sw_addr      (sw_addr),
        .sw_wr_data   (sw_wr_data),
        .sw_ack       (sw_ack),
        .sw_rd_data   (sw_rd_data),
        .sram_req     (sram_req),
        .sram_rd_wr_L (sram_rd_wr_L),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .sram_ack     (sram_ack),
        .sram_rd_data (sram_rd_data),
        .sram_rd_vld  (sram_rd_vld),
        .upd_done     (upd_done),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind: 0 = SRAM write, 1 = host read ack (data checked), 2 = host write ack
    typedef struct {
        int          kind;
        logic [18:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  wr_times[$];
    ev_t mon_e;

    function automatic ev_t mk_ev(input int k, input logic [18:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Behavioural SRAM: zero-wait ack, read data one cycle after accept,
    // upper nibble driven to all ones.
    bit [31:0]   mem [int];
    logic        ack_en = 1'b1;
    logic        rd_hold = 1'b0;
    logic        rd_pend = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        model_vld = 1'b0;
    logic        stray_vld = 1'b0;
    logic [35:0] model_rd_data = '0;

    assign sram_ack     = sram_req & ack_en;
    assign sram_rd_vld  = model_vld | stray_vld;
    assign sram_rd_data = model_rd_data;

    always @(negedge clk) begin
        rd_pend = sram_req && sram_ack && sram_rd_wr_L;
        rd_addr = sram_addr;
        if (sram_req && sram_ack && !sram_rd_wr_L) begin
            mem[int'(sram_addr)] = sram_wr_data[31:0];
        end
    end

    always @(posedge clk) begin
        #1;
        model_vld     = rd_pend && !rd_hold;
        model_rd_data = {4'hF, mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 32'h0};
    end

    // Monitor: every SRAM write and every sw_ack pops the next expected event.
    always @(negedge clk) begin
        if (sram_req && sram_ack && !sram_rd_wr_L) begin
            wr_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sram_write: got addr %0h data %0h expected none", sram_addr, sram_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sram_write_order", 64'(mon_e.kind), 64'd0);
                check("sram_write", {9'd0, sram_addr, sram_wr_data}, {9'd0, mon_e.addr, 4'h0, mon_e.data});
            end
        end
        if (sw_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sw_ack: got sw_ack with data %0h expected none", sw_rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sw_ack_order", 64'(mon_e.kind != 0), 64'd1);
                if (mon_e.kind == 1) begin
                    check("sw_rd_data", 64'(sw_rd_data), 64'(mon_e.data));
                end
            end
        end
    end

    logic [31:0] exp_done = '0;

    task automatic push_upd(input logic [18:0] a, input logic [1:0] f, input logic [31:0] v,
                            input logic [31:0] exp_new, input bit expect_wr);
        int n = 0;
        if (expect_wr) begin
            exp_q.push_back(mk_ev(0, a, exp_new));
            exp_done = exp_done + 32'd1;
        end
        @(negedge clk);
        while (!upd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got upd_ready 0 expected 1");
        end
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_func  = f;
        upd_value = v;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic sw_access(input string name, input bit wr, input logic [18:0] a,
                             input logic [31:0] d, input int exp_lat);
        int n = 0;
        int t0;
        @(posedge clk);
        #1;
        sw_req     = 1'b1;
        sw_wr      = wr;
        sw_addr    = a;
        sw_wr_data = d;
        t0         = cyc;
        @(negedge clk);
        while (!sw_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(cyc - t0), 64'(exp_lat));
        @(posedge clk);
        #1 sw_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check("rst_sram_req", 64'(sram_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sw_ack", 64'(sw_ack), 64'd0);
        check("rst_upd_done", 64'(upd_done), 64'd0);
        check("rst_upd_ready", 64'(upd_ready), 64'd1);
        reset = 1'b0;

        // ADD saturation, SUB floor
        mem[32'h10] = 32'hFFFF_FFF0;
        push_upd(19'h10, UPD_FUNC_ADD, 32'h20, 32'hFFFF_FFFF, 1'b1);
        wait_idle("idle_after_add");
        check("upd_done_add", 64'(upd_done), 64'd1);
        mem[32'h11] = 32'h50;
        push_upd(19'h11, UPD_FUNC_SUB, 32'h100, 32'h0, 1'b1);
        wait_idle("idle_after_sub");
        check("upd_done_sub", 64'(upd_done), 64'd2);

        // MAX / SET back to back on one address
        mem[32'h5] = 32'd7;
        s = wr_times.size();
        push_upd(19'h5, UPD_FUNC_MAX, 32'd3, 32'd7, 1'b1);
        push_upd(19'h5, UPD_FUNC_MAX, 32'd9, 32'd9, 1'b1);
        push_upd(19'h5, UPD_FUNC_SET, 32'h1234, 32'h1234, 1'b1);
        wait_idle("idle_after_maxset");
        check("spacing_1", 64'(wr_times[s+1] - wr_times[s]), 64'd4);
        check("spacing_2", 64'(wr_times[s+2] - wr_times[s+1]), 64'd4);
        check("upd_done_maxset", 64'(upd_done), 64'(exp_done));

        // Backpressure: SRAM stalls, queue fills behind the active op
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_upd(19'h20 + 19'(i), UPD_FUNC_SET, 32'h101 + 32'(i), 32'h101 + 32'(i), 1'b1);
        end
        @(negedge clk);
        check("bp_upd_ready", 64'(upd_ready), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        ack_en = 1'b1;
        wait_idle("idle_after_bp");
        check("upd_done_bp", 64'(upd_done), 64'd10);

        // Host write then read back; upper read nibble is 0xF in the model
        exp_q.push_back(mk_ev(0, 19'h7FFFF, 32'hDEAD_BEEF));
        exp_q.push_back(mk_ev(2, 19'h0, 32'h0));
        sw_access("sw_wr_latency", 1'b1, 19'h7FFFF, 32'hDEAD_BEEF, 3);
        exp_q.push_back(mk_ev(1, 19'h0, 32'hDEAD_BEEF));
        sw_access("sw_rd_latency", 1'b0, 19'h7FFFF, 32'h0, 4);
        wait_idle("idle_after_sw");
        check("sw_rd_data_held", 64'(sw_rd_data), 64'hDEAD_BEEF);

        // Arbitration: last grant was host, so update wins the first tie
        exp_q.push_back(mk_ev(0, 19'h5, 32'h1235));
        exp_q.push_back(mk_ev(1, 19'h0, 32'h1235));
        exp_q.push_back(mk_ev(0, 19'h5, 32'h1200));
        exp_q.push_back(mk_ev(0, 19'h5, 32'h2000));
        exp_done = exp_done + 32'd3;
        @(negedge clk);
        upd_valid = 1'b1; upd_addr = 19'h5; upd_func = UPD_FUNC_ADD; upd_value = 32'd1;
        @(negedge clk);
        upd_addr = 19'h5; upd_func = UPD_FUNC_SUB; upd_value = 32'h35;
        sw_req = 1'b1; sw_wr = 1'b0; sw_addr = 19'h5;
        @(negedge clk);
        upd_addr = 19'h5; upd_func = UPD_FUNC_MAX; upd_value = 32'h2000;
        @(negedge clk);
        upd_valid = 1'b0;
        begin
            int n = 0;
            while (!sw_ack && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("arb_sw_ack_seen", 64'(sw_ack), 64'd1);
        end
        @(posedge clk);
        #1 sw_req = 1'b0;
        wait_idle("idle_after_arb");
        check("upd_done_arb", 64'(upd_done), 64'(exp_done));

        // Reset while the read is outstanding, then a stray read-valid
        mem[32'h30] = 32'd1;
        rd_hold = 1'b1;
        push_upd(19'h30, UPD_FUNC_ADD, 32'd5, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        check("stuck_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_sram_req", 64'(sram_req), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_upd_done", 64'(upd_done), 64'd0);
        reset    = 1'b0;
        rd_hold  = 1'b0;
        exp_done = '0;
        @(posedge clk);
        #1 stray_vld = 1'b1;
        @(posedge clk);
        #1 stray_vld = 1'b0;
        @(negedge clk);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_sram_req", 64'(sram_req), 64'd0);
        push_upd(19'h30, UPD_FUNC_ADD, 32'd5, 32'd6, 1'b1);
        wait_idle("idle_after_reset");
        check("upd_done_after_reset", 64'(upd_done), 64'd1);

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
